l1_fetch_arbiter: RTL and testbench
===================================

Name: l1_fetch_arbiter

Overview:
- Shares one block-fetch engine and its backing byte-wide memory among NUM_CORES private L1 caches in the multicore simulator.
- Each L1 raises a miss request with its block address. The arbiter grants requests round-robin, sequences the engine's start and latency-clear, and returns the filled block to the winner.
- The returned latency is the engine's miss latency plus the cycles the request waited for the shared engine, which models memory contention.

Parameters:
- NUM_CORES, 4, number of requesting L1 caches (2..8)
- ADDR_W, 16, byte address width of the memory
- BLOCK_SIZE_BYTE, 16, cache block size in bytes (power of 2)
- FLAT_W, 5, width of the engine's miss-latency output
- LAT_W, 8, width of the latency returned to requesters (saturating)
- TIMEOUT_CYC, 64, watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CORES  per-core miss request; held high until that core's resp_valid
- req_addr  in  NUM_CORES*ADDR_W  per-core block address (slice i belongs to core i); must stay stable while req_valid is high
- resp_valid  out  NUM_CORES  one-hot, one-cycle completion pulse
- resp_block  out  BLOCK_SIZE_BYTE*8  filled block; valid while any resp_valid bit is high
- resp_latency  out  LAT_W  engine latency plus wait cycles; valid with resp_valid
- resp_err  out  1  timeout flag; valid with resp_valid
- fetch_start  out  1  one-cycle start pulse to the engine
- fetch_lat_clr  out  1  latency-clear to the engine, pulsed together with fetch_start
- fetch_addr  out  ADDR_W  granted address with offset bits forced to 0 (tag,index,0)
- fetch_block  in  BLOCK_SIZE_BYTE*8  block from the engine
- fetch_block_ready  in  1  engine completion, high for one cycle
- fetch_miss_latency  in  FLAT_W  engine latency, valid with fetch_block_ready

Behaviour:
- Reset values:
  - All outputs 0.
  - FSM in IDLE, rr_ptr=0, grant=0.
  - Every wait_cnt[i]=0.
- Reset asserted mid-operation aborts the transaction with no response.
  - The system holds rst_n low for at least BLOCK_SIZE_BYTE+8 cycles so the unreset engine drains.
  - fetch_block_ready is ignored outside WAIT.
- States (FSM):
  - IDLE: if any req_valid is high, pick the first set bit searching from rr_ptr upward with wrap. Latch grant and fetch_addr, then go to ISSUE. No request: stay.
  - ISSUE: fetch_start=1 and fetch_lat_clr=1 for exactly this cycle, then go to WAIT.
  - WAIT: on fetch_block_ready, capture fetch_block and fetch_miss_latency, then go to RESP. Otherwise stay.
  - RESP: resp_valid[grant]=1 for one cycle with resp_block, resp_latency and resp_err. Set rr_ptr=(grant+1) mod NUM_CORES, clear wait_cnt[grant], return to IDLE.
- Throughput and latency:
  - Grant-to-start latency is 1 cycle.
  - Completion-to-response latency is 1 cycle.
  - Back-to-back service inserts exactly one IDLE cycle between RESP and the next ISSUE.
- Wait counters:
  - wait_cnt[i] (LAT_W bits) increments saturating in every cycle where req_valid[i]=1 and core i is not the active grant.
  - The counter is frozen while core i is granted.
- Latency arithmetic:
  - resp_latency = zero-extended fetch_miss_latency + wait_cnt[grant].
  - Sum computed at LAT_W+1 bits and saturated to 2^LAT_W-1.
- Requester handshake:
  - A requester drops req_valid on the edge that samples its resp_valid.
  - The served core therefore cannot be re-granted in the following IDLE cycle.
  - A requester that keeps req_valid high re-requests and is treated as new.
- req_valid falling while granted (protocol violation): the fetch completes and resp_valid still pulses.
- Simultaneous requests: rotation guarantees each pending core is served within NUM_CORES grants.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
  - Defined: a WAIT-state counter runs from ISSUE. Reaching TIMEOUT_CYC cycles without fetch_block_ready forces RESP with resp_err=1, resp_block=0 and resp_latency saturated. A later stray fetch_block_ready is ignored unless in WAIT.
  - Not defined: no counter, WAIT waits indefinitely, resp_err tied to 0.

Decomposition:
- Package l1_arb_pkg holds:
  - FSM state enum (IDLE, ISSUE, WAIT, RESP)
  - clog2-derived widths: core index width, offset width
  - the saturating-add function
- Sub-module rr_arbiter:
  - combinational round-robin pick from (req, rr_ptr)
  - outputs: one-hot grant, encoded index, any_req

Test Plan:
- Engine model returns latency 22 after 22 cycles. Single request from core 2, addr 0x1234 -> fetch_addr=0x1230, one fetch_start/fetch_lat_clr pulse, resp_valid=4'b0100 with model's block, resp_latency=22.
- All 4 cores request at once, rr_ptr=0 -> service order 0,1,2,3. Core 3 resp_latency = 22 + its wait cycles (3×(22+engine handshake)+3×IDLE/ISSUE/RESP), checked against scoreboard.
- Core 1 served, then cores 0 and 1 both request -> core 0 is granted before core 1 (pointer advanced past 1).
- Model latency 31 with core waiting 250 cycles -> resp_latency saturates to 255.
- rst_n pulsed low during WAIT -> all outputs 0 immediately. No resp_valid until a fresh request after release; the next grant starts from core 0.
- With FETCH_TIMEOUT_EN, model never asserts ready -> resp_valid after 64 WAIT cycles with resp_err=1, resp_block=0, resp_latency=255.

Source files
------------

// File: rtl/l1_arb_pkg.sv
// Shared definitions for the L1 fetch arbiter.
//   - arb_state_e : arbiter FSM states
//   - idx_w       : width of an encoded core index
//   - off_w       : width of the byte offset within a cache block
//   - sat_add     : unsigned add saturating to a given width
package l1_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } arb_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned off_w(input int unsigned block_bytes);
        return $clog2(block_bytes);
    endfunction

    // Sum is formed one bit wider than the operands so the carry is never lost.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << w) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : index searched first; the search wraps upward from here
//   gnt_oh_o  : one-hot winner (zero when no request)
//   gnt_idx_o : encoded winner
//   any_req_o : at least one request present
module rr_arbiter #(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = 2
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_oh_o,
    output logic [IdxW-1:0]   gnt_idx_o,
    output logic              any_req_o
);

    logic [IdxW-1:0] cand;

    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        any_req_o = 1'b0;
        cand      = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            cand = IdxW'((32'(ptr_i) + k) % NumReq);
            if (!any_req_o && req_i[cand]) begin
                any_req_o       = 1'b1;
                gnt_idx_o       = cand;
                gnt_oh_o[cand]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_fetch_arbiter.sv
// Shares one block-fetch engine among NUM_CORES L1 caches, round-robin.
// Returned latency = engine miss latency + cycles the winner spent waiting.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_addr  : per-core miss requests (slice i of req_addr is core i)
//   resp_*              : one-cycle response to the served core
//   fetch_start/lat_clr : one-cycle engine kick
//   fetch_addr          : block-aligned granted address
//   fetch_block*/fetch_miss_latency : engine completion
//
// Optional: define FETCH_TIMEOUT_EN to enable a WAIT-state watchdog
// (TIMEOUT_CYC cycles) that forces an error response.
module l1_fetch_arbiter
    import l1_arb_pkg::*;
#(
    parameter int unsigned NUM_CORES       = 4,
    parameter int unsigned ADDR_W          = 16,
    parameter int unsigned BLOCK_SIZE_BYTE = 16,
    parameter int unsigned FLAT_W          = 5,
    parameter int unsigned LAT_W           = 8
`ifdef FETCH_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC     = 64
`endif
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CORES-1:0]         req_valid,
    input  logic [NUM_CORES*ADDR_W-1:0]  req_addr,
    output logic [NUM_CORES-1:0]         resp_valid,
    output logic [BLOCK_SIZE_BYTE*8-1:0] resp_block,
    output logic [LAT_W-1:0]             resp_latency,
    output logic                         resp_err,
    output logic                         fetch_start,
    output logic                         fetch_lat_clr,
    output logic [ADDR_W-1:0]            fetch_addr,
    input  logic [BLOCK_SIZE_BYTE*8-1:0] fetch_block,
    input  logic                         fetch_block_ready,
    input  logic [FLAT_W-1:0]            fetch_miss_latency
);

    localparam int unsigned IDX_W = idx_w(NUM_CORES);
    localparam int unsigned OFF_W = off_w(BLOCK_SIZE_BYTE);
    localparam int unsigned BLK_W = BLOCK_SIZE_BYTE * 8;
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
    localparam logic [LAT_W-1:0]  LAT_MAX  = {LAT_W{1'b1}};

    arb_state_e          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BLK_W-1:0]    block_q, block_d;
    logic [FLAT_W-1:0]   flat_q, flat_d;
    logic [LAT_W-1:0]    wait_cnt_q [NUM_CORES];
    logic [LAT_W-1:0]    wait_cnt_d [NUM_CORES];

    logic [NUM_CORES-1:0] pick_oh;
    logic [IDX_W-1:0]     pick_idx;
    logic                 any_req;
    logic [NUM_CORES-1:0] grant_oh;
    logic [NUM_CORES-1:0] active_mask;
    logic                 timeout_hit;
    logic                 err_flag;

    rr_arbiter #(
        .NumReq (NUM_CORES),
        .IdxW   (IDX_W)
    ) u_rr_arbiter (
        .req_i     (req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_oh_o  (pick_oh),
        .gnt_idx_o (pick_idx),
        .any_req_o (any_req)
    );

    assign grant_oh = NUM_CORES'(1) << grant_q;
    // In IDLE the core being picked this cycle is already considered served, so
    // a lone requester accrues no wait cycles.
    assign active_mask = (state_q == StIdle) ? pick_oh : grant_oh;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             err_q, err_d;

    assign timeout_hit = !fetch_block_ready && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign err_flag    = err_q;

    always_comb begin
        tmo_cnt_d = '0;
        err_d     = err_q;
        if (state_q == StWait) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (timeout_hit) begin
                err_d = 1'b1;
            end
        end else if (state_q == StIdle) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_flag    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        block_d  = block_q;
        flat_d   = flat_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    grant_d = pick_idx;
                    addr_d  = req_addr[pick_idx*ADDR_W +: ADDR_W] & ~OFF_MASK;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StWait;
            StWait: begin
                if (fetch_block_ready) begin
                    block_d = fetch_block;
                    flat_d  = fetch_miss_latency;
                    state_d = StResp;
                end else if (timeout_hit) begin
                    block_d = '0;
                    flat_d  = '0;
                    state_d = StResp;
                end
            end
            StResp: begin
                rr_ptr_d = (grant_q == IDX_W'(NUM_CORES - 1)) ? '0 : grant_q + IDX_W'(1);
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            wait_cnt_d[i] = wait_cnt_q[i];
            if (state_q == StResp && grant_q == IDX_W'(i)) begin
                wait_cnt_d[i] = '0;
            end else if (req_valid[i] && !active_mask[i] && wait_cnt_q[i] != LAT_MAX) begin
                wait_cnt_d[i] = wait_cnt_q[i] + LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
            block_q  <= '0;
            flat_q   <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                wait_cnt_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            block_q    <= block_d;
            flat_q     <= flat_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign fetch_start   = (state_q == StIssue);
    assign fetch_lat_clr = (state_q == StIssue);
    assign fetch_addr    = addr_q;

    always_comb begin
        resp_valid   = '0;
        resp_block   = '0;
        resp_latency = '0;
        resp_err     = 1'b0;
        if (state_q == StResp) begin
            resp_valid   = grant_oh;
            resp_block   = block_q;
            resp_err     = err_flag;
            resp_latency = err_flag ? LAT_MAX :
                LAT_W'(sat_add(32'(flat_q), 32'(wait_cnt_q[grant_q]), LAT_W));
        end
    end

endmodule

// File: tb/tb_l1_fetch_arbiter.sv
// Directed bench for l1_fetch_arbiter with a simple fetch-engine model.
module tb_l1_fetch_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [63:0]  req_addr;
    logic [3:0]   resp_valid;
    logic [127:0] resp_block;
    logic [7:0]   resp_latency;
    logic         resp_err;
    logic         fetch_start;
    logic         fetch_lat_clr;
    logic [15:0]  fetch_addr;
    logic [127:0] fetch_block;
    logic         fetch_block_ready;
    logic [4:0]   fetch_miss_latency;

    int errors = 0;
    int checks = 0;

    int unsigned eng_delay = 22;
    logic [4:0]  eng_lat   = 5'd22;
    bit          eng_never = 1'b0;
    int          start_cnt = 0;
    int          clr_cnt   = 0;

    always #5 clk = ~clk;

    l1_fetch_arbiter u_dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .req_valid          (req_valid),
        .req_addr           (req_addr),
        .resp_valid         (resp_valid),
        .resp_block         (resp_block),
        .resp_latency       (resp_latency),
        .resp_err           (resp_err),
        .fetch_start        (fetch_start),
        .fetch_lat_clr      (fetch_lat_clr),
        .fetch_addr         (fetch_addr),
        .fetch_block        (fetch_block),
        .fetch_block_ready  (fetch_block_ready),
        .fetch_miss_latency (fetch_miss_latency)
    );

    function automatic logic [127:0] blk_of(input logic [15:0] a);
        return {8{a ^ 16'h5A3C}};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic set_addr(input int c, input logic [15:0] a);
        req_addr[c*16 +: 16] = a;
    endtask

    task automatic at_posedge();
        @(posedge clk);
        #1;
    endtask

    // Waits for a response within budget cycles, then drops the served request
    // just after the edge that samples resp_valid.
    task automatic wait_resp(input int unsigned budget, output logic [3:0] v,
                             output logic [127:0] b, output logic [7:0] l, output logic e);
        v = '0;
        b = '0;
        l = '0;
        e = 1'b0;
        for (int unsigned c = 0; c < budget; c++) begin
            @(negedge clk);
            if (resp_valid != 4'b0) begin
                v = resp_valid;
                b = resp_block;
                l = resp_latency;
                e = resp_err;
                break;
            end
        end
        if (v != 4'b0) begin
            at_posedge();
            req_valid = req_valid & ~v;
        end
    endtask

    // Engine model: ready arrives eng_delay cycles after the start pulse.
    initial begin
        fetch_block_ready  = 1'b0;
        fetch_block        = '0;
        fetch_miss_latency = '0;
        forever begin
            @(negedge clk);
            if (fetch_start === 1'b1 && !eng_never) begin
                repeat (eng_delay) @(posedge clk);
                #1;
                fetch_block_ready  = 1'b1;
                fetch_block        = blk_of(fetch_addr);
                fetch_miss_latency = eng_lat;
                @(posedge clk);
                #1;
                fetch_block_ready  = 1'b0;
                fetch_block        = '0;
                fetch_miss_latency = '0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (fetch_start === 1'b1) start_cnt++;
            if (fetch_lat_clr === 1'b1) clr_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [3:0]   v;
        logic [127:0] b;
        logic [7:0]   l;
        logic         e;
        int           s0;
        int           c0;
        int           seen;
        logic [15:0]  addrs [4];

        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_resp_valid", resp_valid, 4'b0);
        check_eq("rst_fetch_start", fetch_start, 1'b0);
        check_eq("rst_fetch_lat_clr", fetch_lat_clr, 1'b0);
        check_eq("rst_fetch_addr", fetch_addr, 16'h0);
        check_eq("rst_resp_latency", resp_latency, 8'h0);
        at_posedge();
        rst_n = 1'b1;

        // Single request from core 2.
        at_posedge();
        s0 = start_cnt;
        c0 = clr_cnt;
        set_addr(2, 16'h1234);
        req_valid[2] = 1'b1;
        @(negedge clk);
        check_eq("t1_no_start_in_idle", fetch_start, 1'b0);
        @(negedge clk);
        check_eq("t1_start_after_grant", fetch_start, 1'b1);
        check_eq("t1_lat_clr_with_start", fetch_lat_clr, 1'b1);
        wait_resp(100, v, b, l, e);
        check_eq("t1_resp_valid", v, 4'b0100);
        check_eq("t1_resp_block", b, blk_of(16'h1230));
        check_eq("t1_resp_latency", l, 8'd22);
        check_eq("t1_resp_err", e, 1'b0);
        check_eq("t1_fetch_addr", fetch_addr, 16'h1230);
        check_eq("t1_start_pulses", start_cnt - s0, 1);
        check_eq("t1_clr_pulses", clr_cnt - c0, 1);
        @(negedge clk);
        check_eq("t1_resp_one_cycle", resp_valid, 4'b0);

        // Reset during WAIT aborts the transaction (core 3 granted, ptr was 3).
        at_posedge();
        set_addr(3, 16'hBEEF);
        req_valid[3] = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_fetch_addr", fetch_addr, 16'h0);
        check_eq("rst_mid_fetch_start", fetch_start, 1'b0);
        check_eq("rst_mid_resp_valid", resp_valid, 4'b0);
        req_valid = '0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (resp_valid != 4'b0 || fetch_start) seen++;
        end
        check_eq("rst_no_stray_activity", seen, 0);

        // All four cores at once from a fresh pointer: order 0,1,2,3.
        addrs[0] = 16'h0010;
        addrs[1] = 16'h2345;
        addrs[2] = 16'h4567;
        addrs[3] = 16'h89AB;
        at_posedge();
        for (int i = 0; i < 4; i++) set_addr(i, addrs[i]);
        req_valid = 4'hF;
        for (int k = 0; k < 4; k++) begin
            wait_resp(200, v, b, l, e);
            check_eq($sformatf("t2_valid_%0d", k), v, 4'b0001 << k);
            check_eq($sformatf("t2_latency_%0d", k), l, 8'(22 + 25 * k));
            check_eq($sformatf("t2_block_%0d", k), b, blk_of(addrs[k] & 16'hFFF0));
            check_eq($sformatf("t2_err_%0d", k), e, 1'b0);
        end

        // Core 1 alone, then cores 0 and 1 together: pointer sits past 1.
        at_posedge();
        set_addr(1, 16'h0F0F);
        req_valid[1] = 1'b1;
        wait_resp(100, v, b, l, e);
        check_eq("t3_first_valid", v, 4'b0010);
        check_eq("t3_first_latency", l, 8'd22);
        at_posedge();
        set_addr(0, 16'h1111);
        set_addr(1, 16'h2222);
        req_valid = 4'b0011;
        wait_resp(100, v, b, l, e);
        check_eq("t3_core0_first", v, 4'b0001);
        check_eq("t3_core0_latency", l, 8'd22);
        check_eq("t3_core0_block", b, blk_of(16'h1110));
        wait_resp(100, v, b, l, e);
        check_eq("t3_core1_second", v, 4'b0010);
        check_eq("t3_core1_latency", l, 8'd47);

`ifdef FETCH_TIMEOUT_EN
        // Engine never answers: watchdog forces an error response.
        eng_never = 1'b1;
        at_posedge();
        set_addr(2, 16'h3333);
        req_valid[2] = 1'b1;
        wait_resp(200, v, b, l, e);
        check_eq("tmo_valid", v, 4'b0100);
        check_eq("tmo_err", e, 1'b1);
        check_eq("tmo_block", b, 128'h0);
        check_eq("tmo_latency", l, 8'd255);
        eng_never = 1'b0;
`else
        // Core 2 holds the engine 250 cycles; core 3's latency saturates.
        eng_delay = 250;
        eng_lat   = 5'd31;
        at_posedge();
        set_addr(2, 16'h3000);
        set_addr(3, 16'h4000);
        req_valid = 4'b1100;
        wait_resp(400, v, b, l, e);
        check_eq("sat_core2_valid", v, 4'b0100);
        check_eq("sat_core2_latency", l, 8'd31);
        eng_delay = 22;
        wait_resp(400, v, b, l, e);
        check_eq("sat_core3_valid", v, 4'b1000);
        check_eq("sat_core3_latency", l, 8'd255);
        check_eq("sat_core3_block", b, blk_of(16'h4000));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
